// File: rtl/gfx_fb_swap_pkg.sv
`default_nettype none
// gfx_fb_swap_pkg: shared types and helpers for the frame-buffer swap controller.
package gfx_fb_swap_pkg;

  typedef enum logic [1:0] {
    DRAW  = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int MAX_BUFS = 4;
  localparam int IDX_W    = 2;

  // Lowest set bit of the free mask; returns 0 for an empty mask (callers test |mask first).
  function automatic logic [IDX_W-1:0] lowest_free(input logic [MAX_BUFS-1:0] mask);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_BUFS - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gfx_fb_swap_ctrl_detect_falling.sv
`default_nettype none
// detect_falling: registers a level and flags the cycle in which it goes from 1 to 0.
module detect_falling (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic sig_i,
  output logic fall_o
);

  logic sig_q;

  // Idles high so a low level straight out of reset reads as a boundary.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sig_q <= 1'b1;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign fall_o = sig_q & ~sig_i;

endmodule
`default_nettype wire

// File: rtl/gfx_fb_swap_ctrl.sv
`default_nettype none
// gfx_fb_swap_ctrl: N-buffer (2..4) frame-buffer ownership controller (draw / ready / display).
// Define GFX_FB_SWAP_STATS_EN to add the frames_shown_o / frames_dropped_o saturating counters.
module gfx_fb_swap_ctrl
  import gfx_fb_swap_pkg::*;
#(
  parameter int  NUM_BUFS     = 3,
  parameter int  FLUSH_CYCLES = 8,
  parameter int  CNT_BITS     = 16,
  localparam int BUF_BITS     = (NUM_BUFS > 2) ? $clog2(NUM_BUFS) : 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                gfx_last_i,
  input  logic                vga_vsync_i,
  output logic [BUF_BITS-1:0] gfx_buf_idx_o,
  output logic [BUF_BITS-1:0] vga_buf_idx_o,
  output logic                gfx_restart_o,
  output logic                gfx_hold_o,
  output logic                vga_enable_o
`ifdef GFX_FB_SWAP_STATS_EN
  ,
  output logic [CNT_BITS-1:0] frames_shown_o,
  output logic [CNT_BITS-1:0] frames_dropped_o
`endif
);

  localparam int                 FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]    FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [MAX_BUFS-1:0] BUF_MASK  = MAX_BUFS'((1 << NUM_BUFS) - 1);
  localparam logic [IDX_W-1:0]   DISP_RST   = IDX_W'(NUM_BUFS - 1);
  localparam logic [MAX_BUFS-1:0] FREE_RST  = BUF_MASK & ~MAX_BUFS'(1) & ~(MAX_BUFS'(1) << DISP_RST);

  state_e              state_q, state_d;
  logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [IDX_W-1:0]    w_q, w_d;
  logic [IDX_W-1:0]    disp_q, disp_d;
  logic [IDX_W-1:0]    rdy_q, rdy_d;
  logic                rdy_vld_q, rdy_vld_d;
  logic [MAX_BUFS-1:0] free_q, free_d;
  logic                restart_q, restart_d;
  logic                hold_q, hold_d;
  logic                vga_en_q, vga_en_d;

  logic                vs_fall;
  logic                promote;
  logic                complete;
  logic [IDX_W-1:0]    pick;

  detect_falling u_vs_fall (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .sig_i     (vga_vsync_i),
    .fall_o    (vs_fall)
  );

  assign promote  = vs_fall & vga_en_q & rdy_vld_q;
  assign complete = (state_q == FLUSH) && (flush_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    w_d         = w_q;
    disp_d      = disp_q;
    rdy_d       = rdy_q;
    rdy_vld_d   = rdy_vld_q;
    free_d      = free_q;
    restart_d   = 1'b0;
    hold_d      = hold_q;
    vga_en_d    = vga_en_q;
    pick        = '0;

    // Promotion reads R as it stood at cycle start; a simultaneous completion sees the result.
    if (promote) begin
      free_d[disp_q] = 1'b1;
      disp_d         = rdy_q;
      rdy_vld_d      = 1'b0;
    end

    case (state_q)
      DRAW: begin
        if (gfx_last_i) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LOAD;
          hold_d      = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt_q != '0) begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end else begin
          if (!vga_en_q) begin
            free_d[disp_q] = 1'b1;
            disp_d         = w_q;
            vga_en_d       = 1'b1;
          end else begin
            if (rdy_vld_q && !promote) free_d[rdy_q] = 1'b1;
            rdy_d     = w_q;
            rdy_vld_d = 1'b1;
          end
          if (|free_d) begin
            pick         = lowest_free(free_d);
            w_d          = pick;
            free_d[pick] = 1'b0;
            restart_d    = 1'b1;
            hold_d       = 1'b0;
            state_d      = DRAW;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // The display buffer released by this promotion is the only free one.
        if (promote) begin
          w_d            = disp_q;
          free_d[disp_q] = 1'b0;
          restart_d      = 1'b1;
          hold_d         = 1'b0;
          state_d        = DRAW;
        end
      end
      default: begin
        state_d = DRAW;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= DRAW;
      flush_cnt_q <= '0;
      w_q         <= '0;
      disp_q      <= DISP_RST;
      rdy_q       <= '0;
      rdy_vld_q   <= 1'b0;
      free_q      <= FREE_RST;
      restart_q   <= 1'b0;
      hold_q      <= 1'b0;
      vga_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      w_q         <= w_d;
      disp_q      <= disp_d;
      rdy_q       <= rdy_d;
      rdy_vld_q   <= rdy_vld_d;
      free_q      <= free_d;
      restart_q   <= restart_d;
      hold_q      <= hold_d;
      vga_en_q    <= vga_en_d;
    end
  end

  assign gfx_buf_idx_o = w_q[BUF_BITS-1:0];
  assign vga_buf_idx_o = disp_q[BUF_BITS-1:0];
  assign gfx_restart_o = restart_q;
  assign gfx_hold_o    = hold_q;
  assign vga_enable_o  = vga_en_q;

`ifdef GFX_FB_SWAP_STATS_EN
  logic                shown_inc;
  logic                dropped_inc;
  logic [CNT_BITS-1:0] shown_q;
  logic [CNT_BITS-1:0] dropped_q;

  assign shown_inc   = promote | (complete & ~vga_en_q);
  assign dropped_inc = complete & vga_en_q & rdy_vld_q & ~promote;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      shown_q   <= '0;
      dropped_q <= '0;
    end else begin
      if (shown_inc && !(&shown_q))     shown_q   <= shown_q + CNT_BITS'(1);
      if (dropped_inc && !(&dropped_q)) dropped_q <= dropped_q + CNT_BITS'(1);
    end
  end

  assign frames_shown_o   = shown_q;
  assign frames_dropped_o = dropped_q;
`else
  localparam int unused_cnt_bits = CNT_BITS;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gfx_fb_swap_ctrl.sv
`default_nettype none
// tb_gfx_fb_swap_ctrl: directed vector table, hand sequences and randomized model comparison.
module tb_gfx_fb_swap_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst3_n, last3, vs3;
  logic [1:0] gfx3, vga3;
  logic       rs3, hold3, en3;
  logic       rst2_n, last2, vs2;
  logic [0:0] gfx2, vga2;
  logic       rs2, hold2, en2;
`ifdef GFX_FB_SWAP_STATS_EN
  logic [15:0] sh3, dr3, sh2, dr2;
`endif

  gfx_fb_swap_ctrl #(.NUM_BUFS(3), .FLUSH_CYCLES(8), .CNT_BITS(16)) u_dut3 (
    .clk_i(clk), .reset_n_i(rst3_n), .gfx_last_i(last3), .vga_vsync_i(vs3),
    .gfx_buf_idx_o(gfx3), .vga_buf_idx_o(vga3), .gfx_restart_o(rs3),
    .gfx_hold_o(hold3), .vga_enable_o(en3)
`ifdef GFX_FB_SWAP_STATS_EN
    , .frames_shown_o(sh3), .frames_dropped_o(dr3)
`endif
  );

  gfx_fb_swap_ctrl #(.NUM_BUFS(2), .FLUSH_CYCLES(2), .CNT_BITS(16)) u_dut2 (
    .clk_i(clk), .reset_n_i(rst2_n), .gfx_last_i(last2), .vga_vsync_i(vs2),
    .gfx_buf_idx_o(gfx2), .vga_buf_idx_o(vga2), .gfx_restart_o(rs2),
    .gfx_hold_o(hold2), .vga_enable_o(en2)
`ifdef GFX_FB_SWAP_STATS_EN
    , .frames_shown_o(sh2), .frames_dropped_o(dr2)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: buffers tracked by role, free set derived as "not W/D/valid R".
  typedef struct {
    int w, d, r;
    bit rv, en, busy, holding, restart, hold, vs_prev;
    int left, shown, dropped;
  } mdl_t;

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  function automatic mdl_t mstep(input mdl_t s, input bit rst_n, input bit last,
                                 input bit vs, input int nb, input int fc);
    mdl_t n;
    bit   fall, promote, done, found;
    n = s;
    if (!rst_n) begin
      n = '{default: 0};
      n.d = nb - 1;
      n.vs_prev = 1'b1;
      return n;
    end
    fall      = s.vs_prev && !vs;
    n.vs_prev = vs;
    n.restart = 1'b0;
    promote   = fall && s.en && s.rv;
    done      = 1'b0;
    if (s.busy) begin
      n.left = s.left - 1;
      done   = (n.left == 0);
    end
    if (promote) begin
      n.d = s.r;
      n.rv = 1'b0;
      n.shown = sat_inc(n.shown);
    end
    if (done) begin
      n.busy = 1'b0;
      if (!s.en) begin
        n.d = s.w;
        n.en = 1'b1;
        n.shown = sat_inc(n.shown);
      end else begin
        if (s.rv && !promote) n.dropped = sat_inc(n.dropped);
        n.r = s.w;
        n.rv = 1'b1;
      end
      found = 1'b0;
      for (int b = 0; b < nb; b++) begin
        if (!found && b != n.d && !(n.rv && b == n.r)) begin
          found = 1'b1;
          n.w = b;
        end
      end
      if (found) n.restart = 1'b1;
      else       n.holding = 1'b1;
    end else if (s.holding && promote) begin
      n.w = s.d;
      n.holding = 1'b0;
      n.restart = 1'b1;
    end else if (!s.busy && !s.holding && last) begin
      n.busy = 1'b1;
      n.left = fc;
    end
    n.hold = n.busy || n.holding;
    return n;
  endfunction

  mdl_t m3, m2;
  always @(posedge clk) begin
    m3 = mstep(m3, rst3_n, last3, vs3, 3, 8);
    m2 = mstep(m2, rst2_n, last2, vs2, 2, 2);
  end

  bit rnd_on = 1'b0;
  bit prev_rs3 = 1'b0, prev_rs2 = 1'b0;
  always @(negedge clk) begin
    if (rnd_on) begin
      check("rnd3_gfx", gfx3, m3.w);
      check("rnd3_vga", vga3, m3.d);
      check("rnd3_restart", rs3, m3.restart);
      check("rnd3_hold", hold3, m3.hold);
      check("rnd3_en", en3, m3.en);
      check("rnd2_gfx", gfx2, m2.w);
      check("rnd2_vga", vga2, m2.d);
      check("rnd2_restart", rs2, m2.restart);
      check("rnd2_hold", hold2, m2.hold);
      check("rnd2_en", en2, m2.en);
      if (!hold3) check("rnd3_w_ne_d", int'(gfx3 != vga3), 1);
      if (prev_rs3) check("rnd3_restart_back2back", rs3, 0);
      if (prev_rs2) check("rnd2_restart_back2back", rs2, 0);
`ifdef GFX_FB_SWAP_STATS_EN
      check("rnd3_shown", sh3, m3.shown);
      check("rnd3_dropped", dr3, m3.dropped);
      check("rnd2_shown", sh2, m2.shown);
      check("rnd2_dropped", dr2, m2.dropped);
`endif
    end
    prev_rs3 = rs3;
    prev_rs2 = rs2;
  end

  typedef struct {
    bit rst_n, last, vs;
    int rep;
    int gfx, vga, rs, hold, en, shown, dropped;
  } vec_t;

  vec_t tbl[25];

  initial begin
    //          rst last vs rep gfx vga rs hold en shown drop
    tbl[0]  = '{0, 0, 1, 2,  0, 2, 0, 0, 0, 0, 0};  // reset state
    tbl[1]  = '{1, 1, 1, 1,  0, 2, 0, 1, 0, 0, 0};  // first frame done -> flush
    tbl[2]  = '{1, 0, 1, 7,  0, 2, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 1, 1,  1, 0, 1, 0, 1, 1, 0};  // first frame shown without vsync
    tbl[4]  = '{1, 0, 1, 1,  1, 0, 0, 0, 1, 1, 0};
    tbl[5]  = '{1, 1, 1, 1,  1, 0, 0, 1, 1, 1, 0};
    tbl[6]  = '{1, 0, 1, 8,  2, 0, 1, 0, 1, 1, 0};  // frame 1 ready
    tbl[7]  = '{1, 0, 0, 1,  2, 1, 0, 0, 1, 2, 0};  // vsync swap
    tbl[8]  = '{1, 0, 1, 1,  2, 1, 0, 0, 1, 2, 0};
    tbl[9]  = '{1, 1, 1, 1,  2, 1, 0, 1, 1, 2, 0};
    tbl[10] = '{1, 0, 1, 8,  0, 1, 1, 0, 1, 2, 0};  // freed buffer 0 reused
    tbl[11] = '{1, 1, 1, 1,  0, 1, 0, 1, 1, 2, 0};
    tbl[12] = '{1, 0, 1, 8,  2, 1, 1, 0, 1, 2, 1};  // older ready frame dropped
    tbl[13] = '{1, 0, 0, 1,  2, 0, 0, 0, 1, 3, 1};  // later frame displayed
    tbl[14] = '{1, 0, 1, 1,  2, 0, 0, 0, 1, 3, 1};
    tbl[15] = '{1, 1, 1, 1,  2, 0, 0, 1, 1, 3, 1};
    tbl[16] = '{1, 0, 1, 8,  1, 0, 1, 0, 1, 3, 1};
    tbl[17] = '{1, 1, 1, 1,  1, 0, 0, 1, 1, 3, 1};
    tbl[18] = '{1, 0, 1, 7,  1, 0, 0, 1, 1, 3, 1};
    tbl[19] = '{1, 0, 0, 1,  0, 2, 1, 0, 1, 4, 1};  // vsync coincides with completion
    tbl[20] = '{1, 0, 1, 1,  0, 2, 0, 0, 1, 4, 1};
    tbl[21] = '{1, 1, 1, 1,  0, 2, 0, 1, 1, 4, 1};
    tbl[22] = '{1, 0, 1, 3,  0, 2, 0, 1, 1, 4, 1};
    tbl[23] = '{0, 0, 1, 1,  0, 2, 0, 0, 0, 0, 0};  // reset mid-flush
    tbl[24] = '{1, 0, 1, 10, 0, 2, 0, 0, 0, 0, 0};

    rst3_n = 1'b0; last3 = 1'b0; vs3 = 1'b1;
    rst2_n = 1'b0; last2 = 1'b0; vs2 = 1'b1;

    for (int i = 0; i < 25; i++) begin
      rst3_n = tbl[i].rst_n;
      last3  = tbl[i].last;
      vs3    = tbl[i].vs;
      repeat (tbl[i].rep) @(negedge clk);
      check($sformatf("vec%0d_gfx", i), gfx3, tbl[i].gfx);
      check($sformatf("vec%0d_vga", i), vga3, tbl[i].vga);
      check($sformatf("vec%0d_restart", i), rs3, tbl[i].rs);
      check($sformatf("vec%0d_hold", i), hold3, tbl[i].hold);
      check($sformatf("vec%0d_en", i), en3, tbl[i].en);
`ifdef GFX_FB_SWAP_STATS_EN
      check($sformatf("vec%0d_shown", i), sh3, tbl[i].shown);
      check($sformatf("vec%0d_dropped", i), dr3, tbl[i].dropped);
`endif
    end

    // Two buffers: second frame must wait for the vsync swap.
    rst2_n = 1'b1;
    last2 = 1'b1;
    @(negedge clk);
    last2 = 1'b0;
    repeat (2) @(negedge clk);
    check("db_first_gfx", gfx2, 1);
    check("db_first_vga", vga2, 0);
    check("db_first_restart", rs2, 1);
    check("db_first_en", en2, 1);
    last2 = 1'b1;
    @(negedge clk);
    last2 = 1'b0;
    repeat (2) @(negedge clk);
    check("db_stall_hold", hold2, 1);
    check("db_stall_restart", rs2, 0);
    repeat (5) @(negedge clk);
    check("db_stall_hold_late", hold2, 1);
    check("db_stall_vga", vga2, 0);
    vs2 = 1'b0;
    @(negedge clk);
    vs2 = 1'b1;
    check("db_swap_vga", vga2, 1);
    check("db_swap_gfx", gfx2, 0);
    check("db_swap_restart", rs2, 1);
    check("db_swap_hold", hold2, 0);
    @(negedge clk);
    check("db_swap_restart_end", rs2, 0);

    // Randomized phase against the reference model.
    rst3_n = 1'b0; rst2_n = 1'b0; last3 = 1'b0; last2 = 1'b0;
    @(negedge clk);
    rnd_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      rst3_n = ($urandom_range(0, 299) != 0);
      rst2_n = ($urandom_range(0, 299) != 0);
      vs3    = ($urandom_range(0, 19) != 0);
      vs2    = ($urandom_range(0, 11) != 0);
      last3  = !m3.busy && !m3.holding && ($urandom_range(0, 3) == 0);
      last2  = !m2.busy && !m2.holding && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    rnd_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
